// File: rtl/seq_game_ctrl_pkg.sv
// seq_game_ctrl_pkg: shared state encoding and symbol codes for the sequence game
package seq_game_ctrl_pkg;
  localparam int SYM_W = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_SHOW, ST_GAP, ST_INPUT, ST_WIN, ST_LOSE} state_t;
  localparam logic [SYM_W-1:0] SYM_0 = 2'd0;
  localparam logic [SYM_W-1:0] SYM_1 = 2'd1;
  localparam logic [SYM_W-1:0] SYM_2 = 2'd2;
  localparam logic [SYM_W-1:0] SYM_ILLEGAL = 2'b11;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/seq_game_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that saturates at zero; o_expire marks the last cycle of a phase
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= reset ? '0 : i_load ? i_value : r_cnt - W'(r_cnt != '0);
  assign o_expire = r_cnt == '0;
endmodule

// File: rtl/seq_game_ctrl.sv
// seq_game_ctrl: Simon-style playback of a latched symbol pattern and checking of player presses
module seq_game_ctrl
  import seq_game_ctrl_pkg::*;
#(
  parameter int NUM_SYMS       = 9,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SYM_W*NUM_SYMS-1:0] pattern,
  input  logic                      pattern_valid,
  input  logic                      btn_valid,
  input  logic [SYM_W-1:0]          btn_sym,
  output logic                      show_valid,
  output logic [SYM_W-1:0]          show_sym,
  output logic [3:0]                round,
  output logic                      busy,
  output logic                      win,
  output logic                      lose
);
  localparam int PW = SYM_W * NUM_SYMS;
  localparam int MAXC = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] L_SHOW = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] L_GAP  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] L_TO   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_R = 4'(NUM_SYMS);
  state_t r_state, w_state_n;
  logic [PW-1:0] r_pat, w_pat_n;
  logic [3:0] r_idx, w_idx_n, r_round, w_round_n;
  logic w_load, w_expire, w_illegal, w_last;
  logic [TW-1:0] w_load_val;
  logic [SYM_W-1:0] w_sym;
  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );
  always_comb begin
    w_illegal = 1'b0;
    for (int i = 0; i < NUM_SYMS; i++)
      w_illegal |= pattern[SYM_W*i +: SYM_W] == SYM_ILLEGAL;
  end
  assign w_sym  = SYM_W'(r_pat >> (SYM_W * r_idx));
  assign w_last = r_idx == r_round - 4'd1;
  always_comb begin
    w_state_n  = r_state;
    w_pat_n    = r_pat;
    w_idx_n    = r_idx;
    w_round_n  = r_round;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_SHOW: if (w_expire) begin
        w_state_n  = ST_GAP;
        w_load     = 1'b1;
        w_load_val = L_GAP;
      end
      ST_GAP: if (w_expire) begin
        w_load     = 1'b1;
        w_state_n  = w_last ? ST_INPUT : ST_SHOW;
        w_idx_n    = w_last ? 4'd0 : r_idx + 4'd1;
        w_load_val = w_last ? L_TO : L_SHOW;
      end
      ST_INPUT: if (btn_valid) begin
        if (btn_sym != w_sym) w_state_n = ST_LOSE;
        else if (!w_last) begin
          w_idx_n    = r_idx + 4'd1;
          w_load     = 1'b1;
          w_load_val = L_TO;
        end else if (r_round == LAST_R) w_state_n = ST_WIN;
        else begin
          w_state_n  = ST_SHOW;
          w_round_n  = r_round + 4'd1;
          w_idx_n    = 4'd0;
          w_load     = 1'b1;
          w_load_val = L_SHOW;
        end
      end else if (w_expire) w_state_n = ST_LOSE;
      default: if (start && pattern_valid && !w_illegal) begin
        w_state_n  = ST_SHOW;
        w_pat_n    = pattern;
        w_round_n  = 4'd1;
        w_idx_n    = 4'd0;
        w_load     = 1'b1;
        w_load_val = L_SHOW;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pat   <= '0;
      r_idx   <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_n;
      r_pat   <= w_pat_n;
      r_idx   <= w_idx_n;
      r_round <= w_round_n;
    end
  end
  assign show_valid = r_state == ST_SHOW;
  assign show_sym   = show_valid ? w_sym : SYM_0;
  assign round      = r_round;
  assign busy       = r_state inside {ST_SHOW, ST_GAP, ST_INPUT};
  assign win        = r_state == ST_WIN;
  assign lose       = r_state == ST_LOSE;
endmodule
